// File: rtl/opacc_seq.sv
// Purpose: command sequencer for one outer-product accumulator cell bank (LOAD / MACC / STORE).
// Latency: one cycle from command accept to the stream opening; done/err are pulsed one cycle after the final beat or accept.
// Backpressure: only the active state's stream sees ready/valid; stalls hold the beat count; flush drops the in-flight beat.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_op,       command handshake: op 0=LOAD 1=MACC 2=STORE 3=illegal,
//   cmd_reg, cmd_len                   target register and MACC beat count
//   flush                              synchronous abort to IDLE
//   ld_valid/ld_ready                  C-load stream handshake
//   op_valid/op_ready                  A/B operand stream handshake
//   st_valid/st_ready                  C-store stream handshake
//   ci_valid, ab_valid                 cell load / accumulate strobes
//   cld_addr, ab_addr, cst_addr        cell register addresses (current command's register)
//   busy, done, err                    status: not idle, completion pulse, illegal-command pulse
module opacc_seq #(
  parameter int NREGS  = 2,
  parameter int LEN_W  = 16,
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_reg,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              flush,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              op_valid,
  output logic              op_ready,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              ci_valid,
  output logic              ab_valid,
  output logic [ADDR_W-1:0] cld_addr,
  output logic [ADDR_W-1:0] ab_addr,
  output logic [ADDR_W-1:0] cst_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MACC  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_MACC  = 2'd1;
  localparam logic [1:0] OP_ILLEG = 2'd3;

  state_t              state;
  logic [ADDR_W-1:0]   cur_reg;
  logic [LEN_W-1:0]    cnt;
  logic                out_of_reset;  // keeps cmd_ready low while reset is held and until the first edge after release
  logic                done_q;
  logic                err_q;

  logic                accept;
  logic                bad_cmd;
  logic                st_fire;

  // Stream enables are decoded from the registered state; flush masks them so the in-flight beat is dropped.
  assign cmd_ready = out_of_reset & (state == S_IDLE) & ~flush;
  assign ld_ready  = (state == S_LOAD)  & ~flush;
  assign op_ready  = (state == S_MACC)  & ~flush;
  assign st_valid  = (state == S_STORE) & ~flush;

  assign ci_valid  = ld_valid & ld_ready;
  assign ab_valid  = op_valid & op_ready;
  assign st_fire   = st_valid & st_ready;

  assign cld_addr  = cur_reg;
  assign ab_addr   = cur_reg;
  assign cst_addr  = cur_reg;

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  assign accept    = cmd_valid & cmd_ready;
  // A zero-length MACC is rejected so the beat counter can never wrap.
  assign bad_cmd   = (cmd_op == OP_ILLEG) | ((cmd_op == OP_MACC) & (cmd_len == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cur_reg      <= '0;
      cnt          <= '0;
      out_of_reset <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              cur_reg <= cmd_reg;
              cnt     <= cmd_len;
              if (bad_cmd) begin
                err_q <= 1'b1;
              end else begin
                case (cmd_op)
                  OP_LOAD: state <= S_LOAD;
                  OP_MACC: state <= S_MACC;
                  default: state <= S_STORE;
                endcase
              end
            end
          end
          S_LOAD: begin
            if (ci_valid) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
          S_MACC: begin
            if (ab_valid) begin
              cnt <= cnt - LEN_W'(1);
              if (cnt == LEN_W'(1)) begin
                state  <= S_IDLE;
                done_q <= 1'b1;
              end
            end
          end
          S_STORE: begin
            if (st_fire) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_opacc_seq.sv
// Purpose: self-checking bench for opacc_seq; expected strobes/pulses are queued by stimulus and popped by a monitor.
// Latency: stimulus drives 1 time unit after posedge; all sampling on negedge or between edges.
// Backpressure: stream valids/readies are driven per directed scenario.
module tb_opacc_seq;

  localparam int NREGS  = 2;
  localparam int LEN_W  = 16;
  localparam int ADDR_W = 1;

  localparam int EV_CI   = 0;
  localparam int EV_AB   = 1;
  localparam int EV_ST   = 2;
  localparam int EV_DONE = 3;
  localparam int EV_ERR  = 4;

  logic              clk;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_reg;
  logic [LEN_W-1:0]  cmd_len;
  logic              flush;
  logic              ld_valid;
  logic              ld_ready;
  logic              op_valid;
  logic              op_ready;
  logic              st_valid;
  logic              st_ready;
  logic              ci_valid;
  logic              ab_valid;
  logic [ADDR_W-1:0] cld_addr;
  logic [ADDR_W-1:0] ab_addr;
  logic [ADDR_W-1:0] cst_addr;
  logic              busy;
  logic              done;
  logic              err;

  opacc_seq #(.NREGS(NREGS), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len), .flush(flush),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .op_valid(op_valid), .op_ready(op_ready),
    .st_valid(st_valid), .st_ready(st_ready),
    .ci_valid(ci_valid), .ab_valid(ab_valid),
    .cld_addr(cld_addr), .ab_addr(ab_addr), .cst_addr(cst_addr),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int kind;
    int addr;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_done_cyc = -100;
  int  busy_cycles = 0;
  int  ab_count = 0;
  int  ci_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int a);
    ev_t e;
    e.kind = k;
    e.addr = a;
    q.push_back(e);
  endtask

  task automatic pop_ev(input int k, input int a);
    ev_t e;
    total = total + 1;
    if (q.size() == 0) begin
      bad = bad + 1;
      $display("FAIL unexpected_event: got kind %0d addr %0d, expected no event (cycle %0d)", k, a, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || (k <= EV_ST && e.addr != a)) begin
        bad = bad + 1;
        $display("FAIL event_order: got kind %0d addr %0d, expected kind %0d addr %0d (cycle %0d)",
                 k, a, e.kind, e.addr, cyc);
      end
    end
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (ci_valid) begin
      pop_ev(EV_CI, int'(cld_addr));
      ci_count = ci_count + 1;
    end
    if (ab_valid) begin
      pop_ev(EV_AB, int'(ab_addr));
      ab_count = ab_count + 1;
    end
    if (st_valid && st_ready) pop_ev(EV_ST, int'(cst_addr));
    if (done) begin
      pop_ev(EV_DONE, 0);
      last_done_cyc = cyc;
    end
    if (err) pop_ev(EV_ERR, 0);
    if (busy) busy_cycles = busy_cycles + 1;
    check("excl_strobe", 32'(ci_valid & ab_valid), 0);
    check("excl_stream", 32'((32'(ld_ready) + 32'(op_ready) + 32'(st_valid)) > 1), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int r, input int len);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = r[ADDR_W-1:0];
    cmd_len   = len[LEN_W-1:0];
    while (!cmd_ready && n < 50) begin
      tick();
      n = n + 1;
    end
    if (!cmd_ready) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL issue_timeout: cmd_ready got 0 expected 1 within 50 cycles (op %0d)", op);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_len = '0;
    flush = 1'b0; ld_valid = 1'b0; op_valid = 1'b0; st_ready = 1'b0;

    // Reset state
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_strobes", 32'({ld_ready, op_ready, st_valid, ci_valid, ab_valid, done, err}), 0);
    #9;
    reset_n = 1'b1;
    #1;
    check("rel_cmd_ready_before_edge", 32'(cmd_ready), 0);
    tick();
    check("rel_cmd_ready_after_edge", 32'(cmd_ready), 1);

    // LOAD reg1, data arrives after 3 idle cycles
    busy_cycles = 0; ci_count = 0;
    issue(2'd0, 1, 0);
    repeat (3) tick();
    ld_valid = 1'b1;
    push(EV_CI, 1); push(EV_DONE, 0);
    tick();
    ld_valid = 1'b0;
    @(negedge clk);
    check("load_done", 32'(done), 1);
    check("load_idle", 32'(busy), 0);
    tick();
    check("load_busy_cycles", 32'(busy_cycles), 4);
    check("load_ci_count", 32'(ci_count), 1);

    // MACC reg0 len4, operand pattern 1,0,1,1,1
    ab_count = 0;
    pat = 5'b11101;  // bit i = beat i
    issue(2'd1, 0, 4);
    for (int i = 0; i < 5; i++) begin
      op_valid = pat[i];
      if (pat[i]) push(EV_AB, 0);
      if (i == 4) push(EV_DONE, 0);
      tick();
    end
    op_valid = 1'b0;
    @(negedge clk);
    check("macc_done_timing", 32'(done), 1);
    tick();
    check("macc_ab_count", 32'(ab_count), 4);

    // LOAD r1 -> MACC r1 len2 -> STORE r1 with all streams valid
    ld_valid = 1'b1; op_valid = 1'b1; st_ready = 1'b0;
    push(EV_CI, 1); push(EV_DONE, 0);
    push(EV_AB, 1); push(EV_AB, 1); push(EV_DONE, 0);
    push(EV_ST, 1); push(EV_DONE, 0);
    issue(2'd0, 1, 0);
    issue(2'd1, 1, 2);
    issue(2'd2, 1, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      check("store_hold_valid", 32'(st_valid), 1);
      if (i == 0) begin
        check("store_after_macc_done", 32'(cyc - last_done_cyc), 1);
        check("store_addr", 32'(cst_addr), 1);
      end
    end
    tick();
    st_ready = 1'b1;
    tick();
    st_ready = 1'b0; ld_valid = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("store_done", 32'(done), 1);
    check("store_idle", 32'(st_valid), 0);

    // Illegal op and zero-length MACC
    tick();
    busy_cycles = 0;
    ld_valid = 1'b1; op_valid = 1'b1;
    push(EV_ERR, 0); push(EV_ERR, 0);
    issue(2'd3, 0, 0);
    issue(2'd1, 1, 0);
    @(negedge clk);
    check("zero_len_err", 32'(err), 1);
    repeat (3) tick();
    check("illegal_busy_cycles", 32'(busy_cycles), 0);
    ld_valid = 1'b0; op_valid = 1'b0;

    // Flush on the 3rd beat of MACC len8, then a fresh MACC len2
    ab_count = 0;
    op_valid = 1'b1;
    push(EV_AB, 0); push(EV_AB, 0);
    issue(2'd1, 0, 8);
    tick();
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_ab_valid", 32'(ab_valid), 0);
    check("flush_op_ready", 32'(op_ready), 0);
    check("flush_cmd_ready", 32'(cmd_ready), 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'(busy), 0);
    check("flush_no_done", 32'(done), 0);
    check("flush_ab_count", 32'(ab_count), 2);
    tick();
    ab_count = 0;
    push(EV_AB, 1); push(EV_AB, 1); push(EV_DONE, 0);
    issue(2'd1, 1, 2);
    tick();
    tick();
    @(negedge clk);
    check("post_flush_done", 32'(done), 1);
    check("post_flush_ab_count", 32'(ab_count), 2);
    op_valid = 1'b0;
    tick();

    // Asynchronous reset in the middle of a STORE
    st_ready = 1'b0;
    issue(2'd2, 1, 0);
    @(negedge clk);
    check("pre_reset_st_valid", 32'(st_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_st_valid", 32'(st_valid), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_cmd_ready", 32'(cmd_ready), 0);
    check("async_rst_addr", 32'(cst_addr), 0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rst2_cmd_ready_before_edge", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    check("rst2_cmd_ready_after_edge", 32'(cmd_ready), 1);
    repeat (3) tick();

    check("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opacc_seq.md
Name: opacc_seq

Overview:
- Command sequencer for one bank of outer-product accumulator cells: the MPU issue logic hands it LOAD / MACC / STORE commands, and it drives the cells' ci_valid, ab_valid, cld_addr, ab_addr and cst_addr.
- Arbitrates three data streams onto the cell bank: C load, A/B operand beats, C store.
- Serialises all cell activity so that a C load and an A·B accumulate never occur in the same cycle.
- Datapath buses (ci, ai, bj, co) connect directly between streams and cells; this block handles only control, handshakes and beat counting.

Parameters:
- NREGS, 2, accumulator registers per cell; must be ≥2. ADDR_W = $clog2(NREGS), derived.
- LEN_W, 16, width of the MACC beat count.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0=LOAD, 1=MACC, 2=STORE, 3=illegal
- cmd_reg  in  ADDR_W  target accumulator register
- cmd_len  in  LEN_W  MACC beat count (K); ignored for LOAD/STORE
- flush  in  1  synchronous abort to IDLE
- ld_valid / ld_ready  in / out  1  C-load stream handshake
- op_valid / op_ready  in / out  1  A/B operand-pair stream handshake
- st_valid / st_ready  out / in  1  C-store stream handshake (co is the data)
- ci_valid  out  1  cell load strobe
- ab_valid  out  1  cell accumulate strobe
- cld_addr, ab_addr, cst_addr  out  ADDR_W  cell register addresses
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse on an illegal command

Behaviour:
- State machine states: IDLE, LOAD, MACC, STORE.
- cmd_ready=1 only in IDLE and only when flush=0.
- Command accept latches: cur_reg ← cmd_reg; cnt ← cmd_len.
- State transitions on the cycle after accept:
  - LOAD → LOAD; MACC → MACC; STORE → STORE.
  - op=3, or MACC with cmd_len=0: stay IDLE; err=1 on the next cycle; no cell strobe, no done.
- LOAD:
  - ld_ready=1.
  - ci_valid = ld_valid & ld_ready (combinational).
  - On the handshake: next state IDLE; done=1 the following cycle.
- MACC:
  - op_ready=1.
  - ab_valid = op_valid & op_ready (combinational).
  - Each handshake decrements cnt.
  - Handshake with cnt==1: next state IDLE; done next cycle.
  - Beats with op_valid=0 are stalls; cnt holds.
- STORE:
  - st_valid=1; cst_addr=cur_reg throughout.
  - st_ready high: next state IDLE; done next cycle.
  - st_valid stays asserted until accepted.
- Address outputs:
  - cld_addr = ab_addr = cur_reg at all times.
  - cst_addr = cur_reg.
  - All are registered values, stable for the whole command.
- Exclusivity: ld_ready, op_ready and st_valid are mutually exclusive, as are ci_valid and ab_valid. Only the current state's stream sees ready/valid.
- Back-to-back: the minimum gap from a completing handshake to the next cmd_ready is 1 cycle (IDLE). A MACC into reg r followed by a STORE of r therefore reads the updated value; no extra bubble is needed.
- flush:
  - In any state, flush=1 forces next state IDLE and clears cnt.
  - ld_ready, op_ready, st_valid, ci_valid and ab_valid are 0 in the flush cycle (the in-flight beat is dropped).
  - No done pulse.
- Async reset (reset_n=0), immediate:
  - state=IDLE; cur_reg=0; cnt=0.
  - All outputs 0, including cmd_ready.
  - cmd_ready rises on the first clk edge after release.
  - Reset mid-command discards the command; no done.
- Width rules: cnt is LEN_W wide and never wraps, because length 0 is rejected.
- Max command: 2^LEN_W−1 beats.

Test Plan:
- LOAD reg1 then ld_valid after 3 idle cycles:
  - ci_valid=1 for exactly one cycle, cld_addr=1.
  - done one cycle later; busy for 4 cycles (3 waits + beat).
- MACC reg0 len=4 with op_valid pattern 1,0,1,1,1:
  - ab_valid pulses exactly 4 times, ab_addr=0.
  - done on the cycle after the 4th beat; ci_valid never 1.
- LOAD r1 → MACC r1 len=2 → STORE r1, all streams always valid:
  - ci_valid and ab_valid never high together.
  - st_valid appears 1 cycle after the MACC done cycle, cst_addr=1.
  - Hold st_ready=0 for 5 cycles → st_valid stays 1; then accept → done.
- cmd_op=3, then MACC len=0:
  - each gives err=1 one cycle after accept.
  - busy=0 throughout; no cell strobes; no done.
- flush in the 3rd beat of MACC len=8:
  - ab_valid=0 in the flush cycle; IDLE next cycle; no done.
  - A new MACC len=2 then completes after exactly 2 beats.
- reset_n low mid-STORE (asynchronous, between edges):
  - st_valid, busy and cmd_ready go 0 immediately.
  - After release, cmd_ready=1 from the next edge; no done.
